// File: rtl/blk_0fdb73.sv
// Restoring sequential divider: 14-bit dividend / 6-bit divisor -> 8-bit quotient, 6-bit remainder.
// One quotient bit per enabled cycle, valid/ready on both sides, global ce stall.
module blk_0fdb73 #(
    parameter int DIVIDEND_W = 14,
    parameter int DIVISOR_W  = 6,
    parameter int QUOT_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] a,
    input  logic [DIVISOR_W-1:0]  b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [QUOT_W-1:0]     q,
    output logic [DIVISOR_W-1:0]  r,
    output logic                  ovf,
    output logic                  dbz
);

    // state  | meaning
    // S_IDLE | ready for a new operand pair
    // S_CALC | shifting one dividend bit per enabled edge
    // S_DONE | result presented, waiting for out_ready
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    localparam int CNT_W = (QUOT_W > 1) ? $clog2(QUOT_W) : 1;
    localparam int EXT_W = DIVIDEND_W + DIVISOR_W + QUOT_W;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [QUOT_W-1:0]     dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]  div_q, div_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic [QUOT_W-1:0]     quo_q, quo_d;
    logic [QUOT_W-1:0]     q_q, q_d;
    logic [DIVISOR_W-1:0]  r_q, r_d;
    logic                  ovf_q, ovf_d;
    logic                  dbz_q, dbz_d;

    logic [DIVISOR_W:0]    trial;
    logic [DIVISOR_W+1:0]  sub;
    logic                  nonneg;
    logic [DIVISOR_W-1:0]  rem_nxt;
    logic [QUOT_W-1:0]     quo_nxt;
    logic [EXT_W-1:0]      a_ext;
    logic [EXT_W-1:0]      b_sh;
    logic                  unused_bits;

    // Subtraction carries one extra bit so the borrow decides the quotient bit.
    assign trial       = {rem_q, dvd_q[QUOT_W-1]};
    assign sub         = {1'b0, trial} - {2'b00, div_q};
    assign nonneg      = ~sub[DIVISOR_W+1];
    assign rem_nxt     = nonneg ? sub[DIVISOR_W-1:0] : trial[DIVISOR_W-1:0];
    assign quo_nxt     = {quo_q[QUOT_W-2:0], nonneg};
    assign unused_bits = ^{sub[DIVISOR_W], trial[DIVISOR_W]};

    assign a_ext = EXT_W'(a);
    assign b_sh  = EXT_W'(b) << QUOT_W;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        div_d   = div_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        q_d     = q_q;
        r_d     = r_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;
        if (ce) begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        div_d = b;
                        if (b == '0) begin
                            q_d     = '1;
                            r_d     = '0;
                            dbz_d   = 1'b1;
                            ovf_d   = 1'b0;
                            state_d = S_DONE;
                        end else if (a_ext >= b_sh) begin
                            q_d     = '1;
                            r_d     = '0;
                            dbz_d   = 1'b0;
                            ovf_d   = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            // a < b<<QUOT_W, so the bits above the quotient span are already < b.
                            rem_d   = DIVISOR_W'(a >> QUOT_W);
                            dvd_d   = a[QUOT_W-1:0];
                            quo_d   = '0;
                            cnt_d   = CNT_W'(QUOT_W - 1);
                            state_d = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    dvd_d = dvd_q << 1;
                    rem_d = rem_nxt;
                    quo_d = quo_nxt;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        q_d     = quo_nxt;
                        r_d     = rem_nxt;
                        ovf_d   = 1'b0;
                        dbz_d   = 1'b0;
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            div_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            q_q     <= q_d;
            r_q     <= r_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign q         = q_q;
    assign r         = r_q;
    assign ovf       = ovf_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_blk_0fdb73.sv
// Directed bench for the 14/6 sequential divider: vector table plus hand-written
// sequences for back-pressure, ce stall and mid-operation reset.
module tb_blk_0fdb73;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] a;
    logic [5:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  q;
    logic [5:0]  r;
    logic        ovf;
    logic        dbz;

    int n_pass = 0;
    int n_total = 0;

    blk_0fdb73 dut (
        .clk(clk), .reset_n(reset_n), .ce(ce),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .r(r), .ovf(ovf), .dbz(dbz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] a;
        logic [5:0]  b;
        int          hold;
        logic [7:0]  q;
        logic [5:0]  r;
        logic        ovf;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Offers one operand pair; returns the number of edges after the accept edge until out_valid.
    task automatic start_op(input logic [13:0] ta, input logic [5:0] tb_, output int lat);
        @(negedge clk);
        chk("in_ready_before_accept", int'(in_ready), 1);
        a = ta; b = tb_; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_after_handoff", int'(out_valid), 0);
        chk("in_ready_after_handoff", int'(in_ready), 1);
    endtask

    initial begin
        int lat;
        vecs[0]  = '{14'd1000,  6'd7,  0, 8'd142, 6'd6,  1'b0, 1'b0, 8};
        vecs[1]  = '{14'd16065, 6'd63, 0, 8'd255, 6'd0,  1'b0, 1'b0, 8};
        vecs[2]  = '{14'd16383, 6'd63, 0, 8'hFF,  6'd0,  1'b1, 1'b0, 0};
        vecs[3]  = '{14'd12345, 6'd0,  3, 8'hFF,  6'd0,  1'b0, 1'b1, 0};
        vecs[4]  = '{14'd100,   6'd3,  5, 8'd33,  6'd1,  1'b0, 1'b0, 8};
        vecs[5]  = '{14'd0,     6'd1,  0, 8'd0,   6'd0,  1'b0, 1'b0, 8};
        vecs[6]  = '{14'd255,   6'd1,  0, 8'd255, 6'd0,  1'b0, 1'b0, 8};
        vecs[7]  = '{14'd256,   6'd1,  0, 8'hFF,  6'd0,  1'b1, 1'b0, 0};
        vecs[8]  = '{14'd16127, 6'd63, 0, 8'd255, 6'd62, 1'b0, 1'b0, 8};
        vecs[9]  = '{14'd13,    6'd5,  1, 8'd2,   6'd3,  1'b0, 1'b0, 8};
        vecs[10] = '{14'd1,     6'd63, 0, 8'd0,   6'd1,  1'b0, 1'b0, 8};
        vecs[11] = '{14'd5000,  6'd20, 2, 8'd250, 6'd0,  1'b0, 1'b0, 8};

        reset_n = 1'b0; ce = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_q", int'(q), 0);
        chk("rst_r", int'(r), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_dbz", int'(dbz), 0);
        reset_n = 1'b1; ce = 1'b1;

        for (int i = 0; i < 12; i++) begin
            start_op(vecs[i].a, vecs[i].b, lat);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            for (int h = 0; h < vecs[i].hold; h++) begin
                chk($sformatf("v%0d_in_ready_busy", i), int'(in_ready), 0);
                @(negedge clk);
            end
            chk($sformatf("v%0d_out_valid", i), int'(out_valid), 1);
            chk($sformatf("v%0d_q", i), int'(q), int'(vecs[i].q));
            chk($sformatf("v%0d_r", i), int'(r), int'(vecs[i].r));
            chk($sformatf("v%0d_ovf", i), int'(ovf), int'(vecs[i].ovf));
            chk($sformatf("v%0d_dbz", i), int'(dbz), int'(vecs[i].dbz));
            handoff();
            chk($sformatf("v%0d_q_hold", i), int'(q), int'(vecs[i].q));
            chk($sformatf("v%0d_r_hold", i), int'(r), int'(vecs[i].r));
        end

        // ce low for 4 cycles in the middle of the calculation; in_valid while busy must be ignored
        @(negedge clk);
        a = 14'd9999; b = 6'd50; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 14'd1; b = 6'd1;
        lat = 0;
        while (!out_valid && lat < 60) begin
            if (lat == 3) ce = 1'b0;
            if (lat == 7) ce = 1'b1;
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        chk("ce_lat", lat, 12);
        chk("ce_q", int'(q), 199);
        chk("ce_r", int'(r), 49);
        // frozen in DONE: out_ready is not honoured while ce=0
        ce = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("ce_done_frozen", int'(out_valid), 1);
        ce = 1'b1;
        out_ready = 1'b0;
        handoff();

        // reset during CALC discards the operation
        @(negedge clk);
        a = 14'd1000; b = 6'd7; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_out_valid", int'(out_valid), 0);
        lat = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid) lat++;
        end
        chk("midrst_no_pulse", lat, 0);
        start_op(14'd60, 6'd6, lat);
        chk("post_rst_lat", lat, 8);
        chk("post_rst_q", int'(q), 10);
        chk("post_rst_r", int'(r), 0);
        handoff();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
